mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Parametrised arbiter that shares one unified instruction/data memory among NPORTS requesters, e.g. port 0 = data load/store, port 1 = instruction fetch. Each requester uses a valid/ready handshake. Read data returns after a fixed memory latency and is tagged back to the issuing port. Per-port flush drops in-flight read responses, for example on a branch redirect. The block sits between the pipeline stages and the `memory` instance, and replaces ad-hoc PC/ALU address muxing in the top level.

## Interface
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- NPORTS, 2, number of requesters (2..8)
- RD_LATENCY, 1, cycles from read issue to `mem_rdata_i` valid (1..4)
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid_i  in  NPORTS  request valid per port
- req_ready_o  out  NPORTS  request accepted this cycle (one-hot or zero)
- req_addr_i  in  NPORTS*AWIDTH  per-port address; port p occupies bits [p*AWIDTH +: AWIDTH]
- req_wdata_i  in  NPORTS*DWIDTH  per-port store data
- req_we_i  in  NPORTS  1 = store, 0 = load/fetch
- req_funct3_i  in  NPORTS*3  per-port access size/sign (RISC-V funct3)
- flush_i  in  NPORTS  drop this port's outstanding read responses
- rsp_valid_o  out  NPORTS  read response valid for port p
- rsp_data_o  out  DWIDTH  read data, shared by all ports
- mem_addr_o  out  AWIDTH  memory address
- mem_wdata_o  out  DWIDTH  memory store data
- mem_rd_en_o  out  1  memory read enable
- mem_wr_en_o  out  1  memory write enable
- mem_funct3_o  out  3  memory access size
- mem_rdata_i  in  DWIDTH  memory read data, RD_LATENCY cycles after issue
- conflict_cnt_o  out  32  saturating count of cycles with more than one `req_valid_i` set
- busy_o  out  1  at least one read in flight

## Operation
- **Grant (combinational).**
  - Exactly one valid port is granted per cycle; `req_ready_o[g]` is 1 only for the granted port g.
  - Fixed mode: lowest-index valid port wins.
  - RR mode: the search starts at `rr_ptr` and wraps modulo NPORTS.
  - `req_ready_o` depends on `req_valid_i`. Requesters must not make `req_valid_i` depend on `req_ready_o`.
- **Memory drive.** When a grant exists:
  - `mem_addr_o`, `mem_wdata_o` and `mem_funct3_o` take the granted port's fields.
  - `mem_wr_en_o` = `req_we_i[g]`; `mem_rd_en_o` = !`req_we_i[g]`.
- **No grant.** Both enables are 0 and `mem_addr_o`/`mem_wdata_o`/`mem_funct3_o` are 0.
- **RR pointer.** After a grant to port g, `rr_ptr` <= (g+1) mod NPORTS. With no grant, `rr_ptr` holds. In fixed mode the pointer is unused.
- **Response tracking.** A shift pipeline of RD_LATENCY stages, each stage = {valid, port id}.
  - A read grant enters stage 0 with valid=1. Stores enter with valid=0 and produce no response.
  - Stages advance every cycle.
- **Response output.** At the last stage, if valid, `rsp_valid_o[id]` = 1 and `rsp_data_o` = `mem_rdata_i` (combinational pass-through). Otherwise `rsp_data_o` = 0.
- **No back-pressure.** Requesters must consume a response in the cycle it is presented.
- **Flush.** With `flush_i[p]` = 1:
  - Every stage whose id == p is invalidated at the clock edge.
  - A read granted to port p in the same cycle also enters invalid. The memory is still read; the data is discarded.
  - A response being presented combinationally that cycle is also suppressed: `rsp_valid_o[p]` is forced to 0.
- **Busy.** `busy_o` = OR of all stage valids.
- **Conflict counter.** `conflict_cnt_o` increments when popcount(`req_valid_i`) ≥ 2 and saturates at 0xFFFFFFFF.

## Timing
- **Reset values.** `rr_ptr` = 0, all stage valids = 0, `conflict_cnt_o` = 0.
  - `rsp_valid_o` = 0 and `busy_o` = 0 immediately on `rst` assertion (asynchronous).
  - Combinational outputs follow inputs.
- **Acceptance.** A request is accepted in the cycle where `req_valid_i[p]` & `req_ready_o[p]` are both 1.
  - Loads respond exactly RD_LATENCY cycles later.
  - Stores complete at the accepting edge.
- **Throughput.** One access per cycle; back-to-back reads from any ports are fully pipelined.
- **Ordering.** Responses return in issue order.
- **Reset mid-operation.** All in-flight reads are discarded and no response is emitted for them after reset release.
- **Simultaneous events.**
  - A read grant and a last-stage response to the same port in the same cycle are both honoured.
  - A flush and a response on different ports in the same cycle: only the flushed port is affected.

## Test plan
- Fixed mode, NPORTS=2, RD_LATENCY=1: both ports valid, reading 0x01000000 (port 0) and 0x01000004 (port 1).
  - Cycle 0 grants port 0; port 1 is granted in cycle 1.
  - `rsp_valid_o` = 01 in cycle 1 and 10 in cycle 2, with the matching memory words.
  - `conflict_cnt_o` = 1 after cycle 0.
- RR mode, NPORTS=3, all ports valid continuously for 6 cycles -> grants go 0,1,2,0,1,2; `conflict_cnt_o` = 6.
- Port 0 store of 0xDEADBEEF to 0x01000010 with funct3=010, then port 1 load from the same address -> no response for the store; the load returns 0xDEADBEEF RD_LATENCY cycles after its grant.
- RD_LATENCY=3: port 1 issues reads in cycles 0, 1 and 2, then `flush_i[1]` is pulsed in cycle 2.
  - No `rsp_valid_o[1]` is asserted in cycles 3–5.
  - `busy_o` falls after the flush edge.
- RD_LATENCY=2: `rst` is asserted asynchronously mid-cycle with 2 reads in flight -> `rsp_valid_o` and `busy_o` go to 0 immediately; after release, no stale responses appear and `rr_ptr` restarts at 0.
- Drive `conflict_cnt_o` to 0xFFFFFFFE through a forced initial value, then hold 3 conflict cycles -> the counter reads 0xFFFFFFFF and stays there.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one unified instruction/data memory among NPORTS requesters
module mem_port_arbiter #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int NPORTS     = 2,
  parameter int RD_LATENCY = 1,
  parameter int RR_MODE    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        req_valid_i,
  output logic [NPORTS-1:0]        req_ready_o,
  input  logic [NPORTS*AWIDTH-1:0] req_addr_i,
  input  logic [NPORTS*DWIDTH-1:0] req_wdata_i,
  input  logic [NPORTS-1:0]        req_we_i,
  input  logic [NPORTS*3-1:0]      req_funct3_i,
  input  logic [NPORTS-1:0]        flush_i,
  output logic [NPORTS-1:0]        rsp_valid_o,
  output logic [DWIDTH-1:0]        rsp_data_o,
  output logic [AWIDTH-1:0]        mem_addr_o,
  output logic [DWIDTH-1:0]        mem_wdata_o,
  output logic                     mem_rd_en_o,
  output logic                     mem_wr_en_o,
  output logic [2:0]               mem_funct3_o,
  input  logic [DWIDTH-1:0]        mem_rdata_i,
  output logic [31:0]              conflict_cnt_o,
  output logic                     busy_o
);

  localparam int IDW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [IDW-1:0] rr_ptr;
  logic           grant_any;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] idx_w;
  int             idx;
  logic [31:0]    conflict_cnt_q;

  // Read-response tracking pipeline; the last stage lines up with mem_rdata_i
  logic           stg_valid [RD_LATENCY];
  logic [IDW-1:0] stg_id    [RD_LATENCY];

  // Grant search: scanned downwards so the first candidate from the start point wins
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    idx_w     = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx   = (RR_MODE != 0) ? ((int'(rr_ptr) + k) % NPORTS) : k;
      idx_w = IDW'(idx);
      if (req_valid_i[idx_w]) begin
        grant_any = 1'b1;
        grant_id  = idx_w;
      end
    end
  end

  // One-hot ready and memory command taken from the granted port, all zero when idle
  always_comb begin
    req_ready_o  = '0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_funct3_o = '0;
    mem_rd_en_o  = 1'b0;
    mem_wr_en_o  = 1'b0;
    if (grant_any) begin
      req_ready_o[grant_id] = 1'b1;
      mem_addr_o   = req_addr_i[grant_id*AWIDTH +: AWIDTH];
      mem_wdata_o  = req_wdata_i[grant_id*DWIDTH +: DWIDTH];
      mem_funct3_o = req_funct3_i[grant_id*3 +: 3];
      mem_wr_en_o  = req_we_i[grant_id];
      mem_rd_en_o  = !req_we_i[grant_id];
    end
  end

  // Round-robin start point moves just past the last granted port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_id == IDW'(NPORTS - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Saturating count of cycles where more than one requester competes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_q <= '0;
    end else if (($countones(req_valid_i) >= 2) && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;

  // Shift issued reads toward the response slot; a port's flush kills its entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        stg_valid[i] <= 1'b0;
        stg_id[i]    <= '0;
      end
    end else begin
      stg_valid[0] <= mem_rd_en_o && !flush_i[grant_id];
      stg_id[0]    <= grant_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        stg_valid[i] <= stg_valid[i-1] && !flush_i[stg_id[i-1]];
        stg_id[i]    <= stg_id[i-1];
      end
    end
  end

  // Present the returning word to its port unless that port is being flushed right now
  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    if (stg_valid[RD_LATENCY-1]) begin
      rsp_data_o = mem_rdata_i;
      if (!flush_i[stg_id[RD_LATENCY-1]]) begin
        rsp_valid_o[stg_id[RD_LATENCY-1]] = 1'b1;
      end
    end
  end

  // Busy whenever any stage still carries a live read
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      busy_o = busy_o | stg_valid[i];
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Instance A: fixed priority, 2 ports, latency 1
  logic [1:0]  a_vld, a_rdy, a_we, a_flush, a_rsp;
  logic [63:0] a_addr, a_wdata;
  logic [5:0]  a_f3;
  logic [31:0] a_rdata, a_maddr, a_mwdata, a_mrdata, a_cnt;
  logic        a_mrd, a_mwr, a_busy;
  logic [2:0]  a_mf3;

  mem_port_arbiter #(.NPORTS(2), .RD_LATENCY(1), .RR_MODE(0)) u_a (
    .clk(clk), .rst(rst), .req_valid_i(a_vld), .req_ready_o(a_rdy),
    .req_addr_i(a_addr), .req_wdata_i(a_wdata), .req_we_i(a_we),
    .req_funct3_i(a_f3), .flush_i(a_flush), .rsp_valid_o(a_rsp),
    .rsp_data_o(a_rdata), .mem_addr_o(a_maddr), .mem_wdata_o(a_mwdata),
    .mem_rd_en_o(a_mrd), .mem_wr_en_o(a_mwr), .mem_funct3_o(a_mf3),
    .mem_rdata_i(a_mrdata), .conflict_cnt_o(a_cnt), .busy_o(a_busy)
  );

  // Memory behind instance A: write at the edge, registered read
  logic [31:0] mem_a [logic [31:0]];
  always @(posedge clk) begin
    if (a_mwr) mem_a[a_maddr] = a_mwdata;
    if (a_mrd) a_mrdata <= mem_a.exists(a_maddr) ? mem_a[a_maddr] : 32'h0;
  end

  // Instance B: round-robin, 3 ports, latency 3
  logic [2:0]  b_vld, b_rdy, b_flush, b_rsp;
  logic [31:0] b_rdata, b_maddr, b_mwdata, b_cnt;
  logic        b_mrd, b_mwr, b_busy;
  logic [2:0]  b_mf3;

  mem_port_arbiter #(.NPORTS(3), .RD_LATENCY(3), .RR_MODE(1)) u_b (
    .clk(clk), .rst(rst), .req_valid_i(b_vld), .req_ready_o(b_rdy),
    .req_addr_i(96'h0), .req_wdata_i(96'h0), .req_we_i(3'b000),
    .req_funct3_i(9'h0), .flush_i(b_flush), .rsp_valid_o(b_rsp),
    .rsp_data_o(b_rdata), .mem_addr_o(b_maddr), .mem_wdata_o(b_mwdata),
    .mem_rd_en_o(b_mrd), .mem_wr_en_o(b_mwr), .mem_funct3_o(b_mf3),
    .mem_rdata_i(32'hB0B0_0000), .conflict_cnt_o(b_cnt), .busy_o(b_busy)
  );

  // Instance C: round-robin, 2 ports, latency 2
  logic [1:0]  c_vld, c_rdy, c_rsp;
  logic [31:0] c_rdata, c_maddr, c_mwdata, c_cnt;
  logic        c_mrd, c_mwr, c_busy;
  logic [2:0]  c_mf3;

  mem_port_arbiter #(.NPORTS(2), .RD_LATENCY(2), .RR_MODE(1)) u_c (
    .clk(clk), .rst(rst), .req_valid_i(c_vld), .req_ready_o(c_rdy),
    .req_addr_i(64'h0), .req_wdata_i(64'h0), .req_we_i(2'b00),
    .req_funct3_i(6'h0), .flush_i(2'b00), .rsp_valid_o(c_rsp),
    .rsp_data_o(c_rdata), .mem_addr_o(c_maddr), .mem_wdata_o(c_mwdata),
    .mem_rd_en_o(c_mrd), .mem_wr_en_o(c_mwr), .mem_funct3_o(c_mf3),
    .mem_rdata_i(32'hC0C0_0000), .conflict_cnt_o(c_cnt), .busy_o(c_busy)
  );

  initial begin
    rst = 1'b1;
    a_vld = '0; a_we = '0; a_flush = '0; a_addr = '0; a_wdata = '0; a_f3 = '0;
    b_vld = '0; b_flush = '0; c_vld = '0;
    a_mrdata = '0;
    mem_a[32'h0100_0000] = 32'h1111_1111;
    mem_a[32'h0100_0004] = 32'h2222_2222;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Reset state and idle outputs
    check_eq("rst_cnt_a", a_cnt, 0);
    check_eq("rst_busy_a", a_busy, 0);
    check_eq("rst_rsp_a", a_rsp, 0);
    check_eq("rst_cnt_b", b_cnt, 0);
    check_eq("idle_rd_en", a_mrd, 0);
    check_eq("idle_addr", a_maddr, 0);

    // Fixed priority, two competing reads
    next_cycle();
    a_vld = 2'b11;
    a_addr = {32'h0100_0004, 32'h0100_0000};
    #1;
    check_eq("fx_c0_ready", a_rdy, 2'b01);
    check_eq("fx_c0_addr", a_maddr, 32'h0100_0000);
    check_eq("fx_c0_rd_en", a_mrd, 1);
    next_cycle();
    a_vld = 2'b10;
    #1;
    check_eq("fx_c1_rsp", a_rsp, 2'b01);
    check_eq("fx_c1_data", a_rdata, 32'h1111_1111);
    check_eq("fx_c1_ready", a_rdy, 2'b10);
    check_eq("fx_c1_addr", a_maddr, 32'h0100_0004);
    check_eq("fx_c1_cnt", a_cnt, 1);
    next_cycle();
    a_vld = 2'b00;
    #1;
    check_eq("fx_c2_rsp", a_rsp, 2'b10);
    check_eq("fx_c2_data", a_rdata, 32'h2222_2222);
    check_eq("fx_c2_cnt", a_cnt, 1);
    next_cycle();
    #1;
    check_eq("fx_c3_rsp", a_rsp, 0);
    check_eq("fx_c3_busy", a_busy, 0);

    // Store on port 0, then load of the same word on port 1
    a_vld = 2'b01; a_we = 2'b01;
    a_addr[31:0] = 32'h0100_0010; a_wdata[31:0] = 32'hDEAD_BEEF; a_f3[2:0] = 3'b010;
    #1;
    check_eq("st_wr_en", a_mwr, 1);
    check_eq("st_rd_en", a_mrd, 0);
    check_eq("st_wdata", a_mwdata, 32'hDEAD_BEEF);
    check_eq("st_funct3", a_mf3, 3'b010);
    next_cycle();
    a_vld = 2'b10; a_we = 2'b00;
    a_addr[63:32] = 32'h0100_0010; a_f3[5:3] = 3'b010;
    #1;
    check_eq("st_no_rsp", a_rsp, 0);
    check_eq("ld_ready", a_rdy, 2'b10);
    check_eq("ld_funct3", a_mf3, 3'b010);
    next_cycle();
    a_vld = 2'b00;
    #1;
    check_eq("ld_rsp", a_rsp, 2'b10);
    check_eq("ld_data", a_rdata, 32'hDEAD_BEEF);
    next_cycle();

    // Flush suppresses a response being presented; other port unaffected
    a_vld = 2'b01;
    next_cycle();
    a_vld = 2'b10; a_flush = 2'b01;
    #1;
    check_eq("fl_cur_rsp", a_rsp, 0);
    next_cycle();
    a_vld = 2'b00; a_flush = 2'b00;
    #1;
    check_eq("fl_other_rsp", a_rsp, 2'b10);
    check_eq("fl_other_data", a_rdata, 32'hDEAD_BEEF);
    next_cycle();

    // Round-robin rotation with all three ports requesting
    b_vld = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check_eq($sformatf("rr_grant%0d", k), b_rdy, 3'b001 << (k % 3));
      next_cycle();
    end
    b_vld = 3'b000;
    #1;
    check_eq("rr_cnt", b_cnt, 6);
    repeat (4) next_cycle();

    // Latency 3: three reads on port 1, flush in the third cycle
    b_vld = 3'b010;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) b_flush = 3'b010;
      #1;
      check_eq($sformatf("fl3_ready%0d", k), b_rdy, 3'b010);
      if (k == 2) check_eq("fl3_busy_pre", b_busy, 1);
      next_cycle();
    end
    b_vld = 3'b000; b_flush = 3'b000;
    for (int k = 3; k < 6; k++) begin
      #1;
      check_eq($sformatf("fl3_rsp_c%0d", k), b_rsp, 0);
      check_eq($sformatf("fl3_busy_c%0d", k), b_busy, 0);
      next_cycle();
    end

    // Latency 2: asynchronous reset with two reads in flight
    c_vld = 2'b01;
    #1;
    check_eq("ar_c0_ready", c_rdy, 2'b01);
    next_cycle();
    #1;
    check_eq("ar_c1_ready", c_rdy, 2'b01);
    next_cycle();
    c_vld = 2'b00;
    #1;
    check_eq("ar_pre_rsp", c_rsp, 2'b01);
    check_eq("ar_pre_busy", c_busy, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_rsp_now", c_rsp, 0);
    check_eq("ar_busy_now", c_busy, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq($sformatf("ar_stale%0d", k), c_rsp, 0);
      next_cycle();
    end
    c_vld = 2'b11;
    #1;
    check_eq("ar_rr_restart", c_rdy, 2'b01);
    next_cycle();
    c_vld = 2'b00;

    // Conflict counter saturation
    force u_a.conflict_cnt_q = 32'hFFFF_FFFE;
    #1;
    release u_a.conflict_cnt_q;
    #1;
    check_eq("sat_start", a_cnt, 32'hFFFF_FFFE);
    a_vld = 2'b11;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      check_eq($sformatf("sat_%0d", k), a_cnt, 32'hFFFF_FFFF);
    end
    a_vld = 2'b00;
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
